// File: rtl/hb_duty_sched_if.sv
// Duty command handshake between the control processor and the scheduler.
// A command transfers on a clock edge where req_valid and req_ready are both
// high; req_duty must be stable while req_valid is high.
interface hb_duty_sched_if #(
    parameter int DW = 10
);
    logic [DW-1:0] req_duty;
    logic          req_valid;
    logic          req_ready;

    modport master (output req_duty, output req_valid, input req_ready);
    modport slave  (input req_duty, input req_valid, output req_ready);
endinterface

// File: rtl/hb_duty_sched.sv
// Half-bridge duty scheduler: accepts duty commands, slew-limits them at PWM
// period ticks, forces zero duty on faults and gates the PWM outputs.
module hb_duty_sched #(
    parameter int DW   = 10,
    parameter int DMAX = 570,
    parameter int STEP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          tick,
    hb_duty_sched_if.slave req,
    input  logic          fault,
    input  logic          fault_clr,
    output logic [DW-1:0] d_inv,
    output logic          run,
    output logic          fault_lat,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [DW-1:0] DMAX_W = DW'(DMAX);
    localparam logic [DW-1:0] STEP_W = DW'(STEP);

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] cmd;
    logic [DW-1:0] tgt;
    logic [DW-1:0] d_step;
    logic [DW-1:0] d_nx;
    logic          accept;

    assign accept = req.req_valid && req.req_ready;
    // Disabling the inverter retargets to zero immediately; cmd is kept.
    assign tgt    = en ? cmd : '0;

    // One slew-limited step of d_inv toward tgt; lands exactly on tgt when close.
    // Moving down by STEP only happens when d_inv - tgt > STEP, so no wrap.
    always_comb begin
        d_step = d_inv;
        if (tgt > d_inv) begin
            if ((tgt - d_inv) <= STEP_W) d_step = tgt;
            else                         d_step = d_inv + STEP_W;
        end else if (tgt < d_inv) begin
            if ((d_inv - tgt) <= STEP_W) d_step = tgt;
            else                         d_step = d_inv - STEP_W;
        end
    end

    // Next state and next duty; fault overrides everything, including ticks.
    always_comb begin
        state_nx = state;
        d_nx     = d_inv;
        if (fault) begin
            state_nx = S_FAULT;
            d_nx     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    d_nx = '0;
                    if (en) state_nx = S_RAMP;
                end
                S_RAMP: begin
                    if (tick) d_nx = d_step;
                    if (d_inv == tgt && en)         state_nx = S_RUN;
                    else if (d_inv == '0 && !en)    state_nx = S_IDLE;
                end
                S_RUN: begin
                    if (tick) d_nx = d_step;
                    if (tgt != d_inv || !en) state_nx = S_RAMP;
                end
                S_FAULT: begin
                    d_nx = '0;
                    if (fault_clr) state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                    d_nx     = '0;
                end
            endcase
        end
    end

    // State and applied duty registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            d_inv <= '0;
        end else begin
            state <= state_nx;
            d_inv <= d_nx;
        end
    end

    // Command register: cleared by faults, loaded (clamped) on accept.
    // A same-cycle tick reads the old cmd, so a new command waits a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd <= '0;
        end else if (fault) begin
            cmd <= '0;
        end else if (accept) begin
            cmd <= (req.req_duty > DMAX_W) ? DMAX_W : req.req_duty;
        end
    end

    assign run           = (state == S_RAMP) || (state == S_RUN);
    assign fault_lat     = (state == S_FAULT);
    assign req.req_ready = (state != S_FAULT);
    assign busy          = run && (d_inv != tgt);
    assign state_dbg     = state;

endmodule

// File: tb/tb_hb_duty_sched.sv
// Directed bench for hb_duty_sched: hand sequences for ramps/reset plus a
// table of single-cycle vectors for fault handling and ramp-down.
module tb_hb_duty_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tick;
    logic       fault;
    logic       fault_clr;
    logic [9:0] d_inv;
    logic       run;
    logic       fault_lat;
    logic       busy;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd2;

    hb_duty_sched_if #(.DW(10)) req_if ();

    hb_duty_sched #(.DW(10), .DMAX(570), .STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tick      (tick),
        .req       (req_if),
        .fault     (fault),
        .fault_clr (fault_clr),
        .d_inv     (d_inv),
        .run       (run),
        .fault_lat (fault_lat),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       tick;
        logic       valid;
        logic [9:0] duty;
        logic       fault;
        logic       clr;
        logic [9:0] e_d;
        logic       e_run;
        logic       e_flt;
        logic       e_rdy;
        logic       e_busy;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic send(input logic [9:0] duty);
        req_if.req_valid = 1'b1;
        req_if.req_duty  = duty;
        cyc();
        req_if.req_valid = 1'b0;
    endtask

    task automatic add_vec(input logic v_en, input logic v_tick, input logic v_valid,
                           input logic [9:0] v_duty, input logic v_fault, input logic v_clr,
                           input logic [9:0] e_d, input logic e_run, input logic e_flt,
                           input logic e_rdy, input logic e_busy, input string name);
        vec_t v;
        v.en = v_en; v.tick = v_tick; v.valid = v_valid; v.duty = v_duty;
        v.fault = v_fault; v.clr = v_clr; v.e_d = e_d; v.e_run = e_run;
        v.e_flt = e_flt; v.e_rdy = e_rdy; v.e_busy = e_busy; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        // Vectors start in RUN at d_inv=200, cmd=200, en=1.
        //       en tk vl duty  flt clr   d    run flt rdy busy
        add_vec(1, 0, 0, 10'd0,   1, 0, 10'd0,  0, 1, 0, 0, "fault_enter");
        add_vec(1, 0, 0, 10'd0,   1, 1, 10'd0,  0, 1, 0, 0, "clr_while_fault");
        add_vec(1, 0, 1, 10'd300, 1, 0, 10'd0,  0, 1, 0, 0, "no_accept_in_fault");
        add_vec(1, 0, 0, 10'd0,   0, 0, 10'd0,  0, 1, 0, 0, "fault_dropped_no_clr");
        add_vec(1, 0, 0, 10'd0,   0, 1, 10'd0,  0, 0, 1, 0, "fault_clr_exit");
        add_vec(1, 0, 0, 10'd0,   0, 0, 10'd0,  1, 0, 1, 0, "restart_cmd_cleared");
        add_vec(1, 0, 1, 10'd20,  0, 0, 10'd0,  1, 0, 1, 1, "accept_20");
        add_vec(1, 1, 0, 10'd0,   0, 0, 10'd8,  1, 0, 1, 1, "up_8");
        add_vec(1, 1, 0, 10'd0,   0, 0, 10'd16, 1, 0, 1, 1, "up_16");
        add_vec(1, 1, 1, 10'd40,  0, 0, 10'd20, 1, 0, 1, 1, "tick_accept_old_cmd");
        add_vec(1, 0, 0, 10'd0,   0, 0, 10'd20, 1, 0, 1, 1, "hold_between_ticks");
        add_vec(1, 1, 0, 10'd0,   0, 0, 10'd28, 1, 0, 1, 1, "new_cmd_next_tick");
        add_vec(0, 1, 0, 10'd0,   0, 0, 10'd20, 1, 0, 1, 1, "en_off_reverse");
        add_vec(0, 1, 0, 10'd0,   0, 0, 10'd12, 1, 0, 1, 1, "down_12");
        add_vec(0, 1, 0, 10'd0,   0, 0, 10'd4,  1, 0, 1, 1, "down_4");
        add_vec(0, 1, 0, 10'd0,   0, 0, 10'd0,  1, 0, 1, 0, "down_0");
        add_vec(0, 0, 0, 10'd0,   0, 0, 10'd0,  0, 0, 1, 0, "back_to_idle");
        add_vec(0, 0, 0, 10'd0,   1, 0, 10'd0,  0, 1, 0, 0, "fault_from_idle");
        add_vec(0, 0, 0, 10'd0,   0, 1, 10'd0,  0, 0, 1, 0, "clr_from_idle_fault");

        rst = 1'b1; en = 1'b0; tick = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        req_if.req_valid = 1'b0; req_if.req_duty = '0;
        cyc();
        cyc();
        check("rst_d_inv", d_inv, 0);
        check("rst_run", run, 0);
        check("rst_fault_lat", fault_lat, 0);
        check("rst_ready", req_if.req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        cyc();

        // Soft-start ramp to 100.
        en = 1'b1;
        send(10'd100);
        check("ramp_start_run", run, 1);
        check("ramp_start_d", d_inv, 0);
        check("ramp_start_busy", busy, 1);
        for (int k = 1; k <= 13; k++) begin
            tick_once();
            check($sformatf("ramp100_tick%0d", k), d_inv, (8 * k > 100) ? 100 : 8 * k);
            cyc();
            check($sformatf("ramp100_hold%0d", k), d_inv, (8 * k > 100) ? 100 : 8 * k);
        end
        cyc();
        check("ramp100_state_run", state_dbg, ST_RUN);
        check("ramp100_busy_done", busy, 0);

        // Small step down in RUN.
        send(10'd96);
        check("cmd96_busy", busy, 1);
        cyc();
        cyc();
        check("cmd96_hold", d_inv, 100);
        tick_once();
        check("cmd96_d", d_inv, 96);
        check("cmd96_busy_clear", busy, 0);
        cyc();
        cyc();
        check("cmd96_state_run", state_dbg, ST_RUN);

        // Over-range command clamps to 570.
        send(10'd1000);
        for (int k = 1; k <= 63; k++) begin
            tick_once();
            check($sformatf("clamp_tick%0d", k), d_inv, (96 + 8 * k > 570) ? 570 : 96 + 8 * k);
            cyc();
        end
        check("clamp_busy_done", busy, 0);

        // Ramp down to 200 for the fault sequence.
        send(10'd200);
        for (int k = 1; k <= 47; k++) begin
            tick_once();
            check($sformatf("down200_tick%0d", k), d_inv, (570 - 8 * k < 200) ? 200 : 570 - 8 * k);
            cyc();
        end
        cyc();
        check("at200_state_run", state_dbg, ST_RUN);

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en;
            tick = tbl[i].tick;
            req_if.req_valid = tbl[i].valid;
            req_if.req_duty = tbl[i].duty;
            fault = tbl[i].fault;
            fault_clr = tbl[i].clr;
            cyc();
            check({tbl[i].name, "_d_inv"}, d_inv, tbl[i].e_d);
            check({tbl[i].name, "_run"}, run, tbl[i].e_run);
            check({tbl[i].name, "_fault_lat"}, fault_lat, tbl[i].e_flt);
            check({tbl[i].name, "_ready"}, req_if.req_ready, tbl[i].e_rdy);
            check({tbl[i].name, "_busy"}, busy, tbl[i].e_busy);
        end
        tick = 1'b0; req_if.req_valid = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        cyc();
        check("post_table_state", state_dbg, ST_IDLE);

        // Asynchronous reset in the middle of a ramp.
        en = 1'b1;
        send(10'd100);
        for (int k = 1; k <= 6; k++) begin
            tick_once();
            cyc();
        end
        check("pre_rst_d", d_inv, 48);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_d", d_inv, 0);
        check("async_rst_run", run, 0);
        check("async_rst_busy", busy, 0);
        cyc();
        rst = 1'b0;
        #1;
        check("async_rst_ready", req_if.req_ready, 1);
        check("async_rst_fault_lat", fault_lat, 0);
        check("async_rst_state", state_dbg, ST_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
